// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // One writeback request as seen by the register-file write port.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the
// pointer, wrapping modulo NUM_REQ. Holds no state so it can be reused for
// other shared ports.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int cand;

    // Search ptr+1, ptr+2, ... and take the first active request.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (enable && !grant_valid && req[cand[IDX_W-1:0]]) begin
                grant_valid                = 1'b1;
                grant[cand[IDX_W-1:0]]     = 1'b1;
                grant_idx                  = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources with
// round-robin arbitration, a registered write stage, x0 absorption and a
// saturating contention counter.
//
// Handshake: a source presents reqValid/reqAddr/reqData and the transfer
// happens in the cycle where reqValid[i] && reqReady[i]; until then the
// source holds all three stable. Writes to x0 are accepted at once and
// dropped; non-x0 requests compete for one grant per cycle.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    input  logic                          wbStall,
    output logic                          regWrite,
    output logic [ADDR_WIDTH-1:0]         writeAddr,
    output logic [DATA_WIDTH-1:0]         writeData,
    output logic [CNT_WIDTH-1:0]          contentionCount,
    input  logic                          clearCount
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] absorb;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [IDX_W-1:0]   rr_ptr;
    logic               contended;

    // Split each request into "x0, absorb now" and "real write, arbitrate".
    always_comb begin
        eligible = '0;
        absorb   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(REG_ZERO)) begin
                absorb[i] = reqValid[i];
            end else begin
                eligible[i] = reqValid[i];
            end
        end
    end

    assign contended = ($countones(eligible) >= 2);

    // A stall suppresses the grant entirely so the pointer cannot advance.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (rr_ptr),
        .enable      (!wbStall),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign reqReady = resetN ? (absorb | grant) : '0;

    // Register the winning write and move the pointer onto the winner.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            regWrite  <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
        end else begin
            regWrite <= grant_valid;
            if (grant_valid) begin
                writeAddr <= reqAddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                writeData <= reqData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr    <= grant_idx;
            end
        end
    end

    // Saturating count of cycles with two or more real writes waiting.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            contentionCount <= '0;
        end else if (clearCount) begin
            contentionCount <= '0;
        end else if (contended && (contentionCount != '1)) begin
            contentionCount <= contentionCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: NUM_REQ=3, CNT_WIDTH=4 so saturation is
// reachable quickly. Table rows carry stimulus plus the expected ready vector
// and expected winning source; the write each row should produce is queued
// and compared one cycle later.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int EW   = 1 + AW + DW;

    logic                 clock;
    logic                 resetN;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*AW-1:0]   reqAddr;
    logic [NREQ*DW-1:0]   reqData;
    logic [NREQ-1:0]      reqReady;
    logic                 wbStall;
    logic                 regWrite;
    logic [AW-1:0]        writeAddr;
    logic [DW-1:0]        writeData;
    logic [CW-1:0]        contentionCount;
    logic                 clearCount;

    regfile_wb_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .reqValid        (reqValid),
        .reqAddr         (reqAddr),
        .reqData         (reqData),
        .reqReady        (reqReady),
        .wbStall         (wbStall),
        .regWrite        (regWrite),
        .writeAddr       (writeAddr),
        .writeData       (writeData),
        .contentionCount (contentionCount),
        .clearCount      (clearCount)
    );

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] data;
        logic               stall;
        logic               clear;
        logic [NREQ-1:0]    exp_ready;
        int                 exp_src;
    } vec_t;

    vec_t             tbl[$];
    logic [EW-1:0]    exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               exp_cnt = 0;

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] valid,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic stall, input logic clear,
                                input logic [2:0] exp_ready, input int exp_src);
        vec_t v;
        v.valid     = valid;
        v.addr      = {a2, a1, a0};
        v.data      = {d2, d1, d0};
        v.stall     = stall;
        v.clear     = clear;
        v.exp_ready = exp_ready;
        v.exp_src   = exp_src;
        return v;
    endfunction

    // Driver + scoreboard step: drive at negedge, check ready, queue the
    // expected write, then compare the registered outputs one cycle later.
    task automatic apply_vec(input vec_t v, input int idx);
        logic [EW-1:0] e;
        int n;
        reqValid   = v.valid;
        reqAddr    = v.addr;
        reqData    = v.data;
        wbStall    = v.stall;
        clearCount = v.clear;
        #1;
        check($sformatf("ready row%0d", idx), 64'(reqReady), 64'(v.exp_ready));
        if (v.exp_src >= 0)
            e = {1'b1, v.addr[v.exp_src*AW +: AW], v.data[v.exp_src*DW +: DW]};
        else
            e = '0;
        exp_q.push_back(e);
        n = 0;
        for (int i = 0; i < NREQ; i++)
            if (v.valid[i] && v.addr[i*AW +: AW] != 0) n++;
        if (v.clear) exp_cnt = 0;
        else if (n >= 2 && exp_cnt != 15) exp_cnt++;
        @(posedge clock);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check($sformatf("queue row%0d", idx), 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("regWrite row%0d", idx), 64'(regWrite), 64'(e[EW-1]));
            if (e[EW-1]) begin
                check($sformatf("writeAddr row%0d", idx), 64'(writeAddr), 64'(e[DW +: AW]));
                check($sformatf("writeData row%0d", idx), 64'(writeData), 64'(e[DW-1:0]));
            end
        end
        check($sformatf("count row%0d", idx), 64'(contentionCount), 64'(exp_cnt));
    endtask

    initial begin
        int g;
        resetN     = 1'b0;
        reqValid   = 3'b111;
        reqAddr    = {5'd7, 5'd6, 5'd5};
        reqData    = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};
        wbStall    = 1'b0;
        clearCount = 1'b0;

        // Reset held for three cycles with every source requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("reset ready", 64'(reqReady), 64'd0);
            check("reset regWrite", 64'(regWrite), 64'd0);
            check("reset count", 64'(contentionCount), 64'd0);
        end

        // Stimulus table.
        tbl.push_back(mk(3'b111, 5, 6, 7, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, -1));
        tbl.push_back(mk(3'b100, 0, 0, 9, 0, 0, 32'h99, 0, 0, 3'b100, 2));
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            tbl.push_back(mk(3'b111, 1, 2, 3, 32'h100*k + 0, 32'h100*k + 1, 32'h100*k + 2,
                             0, 0, 3'b001 << g, g));
        end
        tbl.push_back(mk(3'b001, 4, 0, 0, 32'h44, 0, 0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b110, 0, 0, 7, 0, 32'hDEAD, 32'h12345678, 0, 0, 3'b110, 2));
        tbl.push_back(mk(3'b111, 13, 14, 15, 32'hD0, 32'hE0, 32'hF0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b001, 10, 0, 0, 32'hA0, 0, 0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b001, 11, 0, 0, 32'hB0, 0, 0, 1, 0, 3'b000, -1));
        tbl.push_back(mk(3'b011, 11, 0, 0, 32'hB0, 32'h5, 0, 1, 0, 3'b010, -1));
        tbl.push_back(mk(3'b101, 11, 0, 12, 32'hB0, 0, 32'hC0, 1, 0, 3'b000, -1));
        tbl.push_back(mk(3'b001, 11, 0, 0, 32'hB0, 0, 0, 1, 0, 3'b000, -1));
        tbl.push_back(mk(3'b001, 11, 0, 0, 32'hB0, 0, 0, 0, 0, 3'b001, 0));
        for (int k = 0; k < 20; k++) begin
            g = (k + 1) % 3;
            tbl.push_back(mk(3'b111, 1, 2, 3, 32'h5000 + k, 32'h6000 + k, 32'h7000 + k,
                             0, 0, 3'b001 << g, g));
        end
        tbl.push_back(mk(3'b111, 1, 2, 3, 32'h8000, 32'h8001, 32'h8002, 0, 1, 3'b001, 0));
        tbl.push_back(mk(3'b111, 1, 2, 3, 32'h9000, 32'h9001, 32'h9002, 0, 0, 3'b010, 1));

        @(negedge clock);
        resetN = 1'b1;
        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Asynchronous reset while a write is on the port.
        reqValid   = 3'b001;
        reqAddr    = {5'd0, 5'd0, 5'd12};
        reqData    = {32'h0, 32'h0, 32'hCAFE0000};
        wbStall    = 1'b0;
        clearCount = 1'b0;
        #1;
        check("async ready", 64'(reqReady), 64'b001);
        @(posedge clock);
        #2;
        check("async pre regWrite", 64'(regWrite), 64'd1);
        check("async pre writeAddr", 64'(writeAddr), 64'd12);
        resetN = 1'b0;
        #1;
        check("async regWrite", 64'(regWrite), 64'd0);
        check("async writeAddr", 64'(writeAddr), 64'd0);
        check("async ready low", 64'(reqReady), 64'd0);
        check("async count", 64'(contentionCount), 64'd0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;

        // After reset the pointer restarts, so source 1 wins over source 2.
        reqValid = 3'b110;
        reqAddr  = {5'd4, 5'd3, 5'd0};
        reqData  = {32'h4444, 32'h3333, 32'h0};
        #1;
        check("post reset ready", 64'(reqReady), 64'b010);
        @(posedge clock);
        @(negedge clock);
        check("post reset regWrite", 64'(regWrite), 64'd1);
        check("post reset writeAddr", 64'(writeAddr), 64'd3);
        check("post reset writeData", 64'(writeData), 64'h3333);
        check("post reset count", 64'(contentionCount), 64'd1);
        reqValid = '0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
